sector_buffer: RTL and testbench
================================

# sector_buffer

Parametrised multi-slot sector store between the floppy decoder and the display/readout path. Replaces the plain byte FIFO: decoded bytes are collected per sector, a sector is committed only when it is complete and its data CRC passed, and committed sectors are streamed out byte by byte with a valid/ready handshake, tagged with their sector number. Bad, short, overlong or overflowing sectors are discarded whole and counted.

## Interface
- SECTOR_BYTES, 512: bytes per sector; power of two, ≥ 2.
- SLOTS, 2: number of sector slots; power of two, ≥ 2.
- HOLD_CYCLES, 12500000: minimum cycles between output bytes when pacing is compiled in; ≥ 1.

- i_Clk  in  1  clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Data  in  8  decoded sector byte.
- i_Valid  in  1  i_Data valid this cycle.
- i_Done  in  1  one-cycle pulse at end of sector; CRC verdict is final.
- i_CRCError  in  1  data CRC failed; sampled with i_Done.
- i_Sector  in  8  sector number; sampled with i_Done.
- i_Rd_Ready  in  1  consumer accepts o_Rd_Data.
- o_Rd_Data  out  8  output byte.
- o_Rd_Valid  out  1  o_Rd_Data valid.
- o_Rd_Sector  out  8  sector number of the slot being read.
- o_Rd_Last  out  1  o_Rd_Data is the last byte of its sector.
- o_Full  out  1  all slots committed.
- o_Dropped  out  8  saturating count of discarded sectors.

## Operation
- Write side: index wr_idx (log2 SECTOR_BYTES + 1 bits), slot pointer wr_slot, flag bad.
- i_Valid with wr_idx < SECTOR_BYTES and not o_Full: byte written to RAM[wr_slot][wr_idx], wr_idx+1.
- i_Valid with wr_idx == SECTOR_BYTES, or while o_Full: byte ignored, bad set.
- i_Done: commit iff !i_CRCError && !bad && wr_idx == SECTOR_BYTES. Commit stores i_Sector in the slot tag, advances wr_slot modulo SLOTS and increments count. Otherwise o_Dropped+1, saturating at 255. Either way wr_idx and bad clear.
- i_Valid and i_Done in the same cycle: the byte belongs to the ending sector and is counted in the length check.
- count is 0..SLOTS; o_Full = (count == SLOTS). Commit and release in the same cycle leave count unchanged.
- Read FSM:
  - R_IDLE: if count > 0, go to R_FETCH.
  - R_FETCH: issue a RAM read at [rd_slot][rd_idx]; go to R_VALID.
  - R_VALID: o_Rd_Valid=1. On i_Rd_Ready:
    - last byte: release the slot (rd_slot+1, count-1, rd_idx=0), go to R_IDLE.
    - otherwise: rd_idx+1, go to R_FETCH, or to R_HOLD when pacing is enabled.
  - R_HOLD: wait out the pacing counter, then go to R_FETCH.
- o_Rd_Data, o_Rd_Sector and o_Rd_Last are stable while o_Rd_Valid=1 and i_Rd_Ready=0.
- o_Rd_Last = (rd_idx == SECTOR_BYTES-1).

## Timing
- Reset values: all outputs 0; wr_idx=0, rd_idx=0, count=0, both slot pointers 0, read FSM in R_IDLE.
- An asserted reset mid-sector or mid-readout discards all contents.
- Commit to first o_Rd_Valid: 3 cycles.
  - Cycle 0: i_Done.
  - Cycle 1: count update, R_IDLE sees count > 0.
  - Cycle 2: R_FETCH.
  - Cycle 3: R_VALID.
- Unpaced throughput: one byte per 2 cycles (R_FETCH/R_VALID alternation).
- RAM: single write port and single read port, registered read, 1-cycle read latency.
- A slot is writable again in the cycle after its release.

## Configuration
- SECTOR_BUFFER_PACE_EN defined:
  - After each non-last handshake, the FSM stays in R_HOLD for HOLD_CYCLES cycles before R_FETCH.
  - Counter width is log2(HOLD_CYCLES+1).
  - Gives a human-readable rate on the 7-segment display.
- SECTOR_BUFFER_PACE_EN undefined: R_HOLD and its counter are absent; handshake goes straight to R_FETCH.
- HOLD_CYCLES is unused in this case.

## Structure
- Shared package floppy_pkg:
  - read-state enum (R_IDLE, R_FETCH, R_VALID, R_HOLD)
  - default SECTOR_BYTES constant
  - drop-counter width constant
- Sub-module sector_ram: simple dual-port SLOTS×SECTOR_BYTES×8 memory with registered read, inferable as block RAM.
- Slot tags are a register array in sector_buffer.

## Test plan
- Good sector (SECTOR_BYTES=4, SLOTS=2, pacing off): write 0x11, 0x22, 0x33, 0x44, then i_Done with i_Sector=0x05 and i_CRCError=0 -> with ready held high, output is 11, 22, 33, 44 with o_Rd_Sector=05 and o_Rd_Last only on 44. First o_Rd_Valid comes 3 cycles after i_Done.
- CRC error: 4 bytes, then i_Done with i_CRCError=1 -> no o_Rd_Valid, o_Dropped=1.
- Short and long sectors:
  - 3 bytes then i_Done -> dropped.
  - 5 bytes then i_Done -> dropped.
  - o_Dropped=2, and the next good sector is read intact.
- Overflow:
  - Commit two sectors with ready low -> o_Full=1.
  - A third sector -> dropped.
  - Raising ready -> the first two sectors come out in order, and o_Full falls after the first o_Rd_Last handshake.
- Backpressure and reset: drop ready mid-sector -> data, sector and last stay stable. Assert i_Reset mid-readout -> all outputs 0 and count=0.
- Pacing (SECTOR_BUFFER_PACE_EN, HOLD_CYCLES=10, ready high): successive handshakes are exactly 12 cycles apart; o_Dropped saturates at 255 after 300 bad sectors.

Source files
------------

// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy read path: read-side state encoding and common constants.
package floppy_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_VALID,
    R_HOLD
  } rd_state_e;

  localparam int unsigned DEFAULT_SECTOR_BYTES = 512;
  localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/sector_ram.sv
// Simple dual-port SLOTS x SECTOR_BYTES x 8 sector memory with a registered read port.
module sector_ram
  import floppy_pkg::*;
#(
  parameter int unsigned SLOTS        = 2,
  parameter int unsigned SECTOR_BYTES = DEFAULT_SECTOR_BYTES,
  localparam int unsigned ADDR_W      = $clog2(SLOTS) + $clog2(SECTOR_BYTES)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [SLOTS*SECTOR_BYTES];
  logic [7:0] rd_data_q;

  // No reset on the array or read register so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sector_buffer.sv
// Multi-slot sector store: commits only complete, CRC-clean sectors and streams them out tagged.
// Optional output pacing via the SECTOR_BUFFER_PACE_EN macro (R_HOLD state + hold counter).
module sector_buffer
  import floppy_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = DEFAULT_SECTOR_BYTES,
  parameter int unsigned SLOTS        = 2,
  parameter int unsigned HOLD_CYCLES  = 12500000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [7:0]        i_Data,
  input  logic              i_Valid,
  input  logic              i_Done,
  input  logic              i_CRCError,
  input  logic [7:0]        i_Sector,
  input  logic              i_Rd_Ready,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Rd_Valid,
  output logic [7:0]        o_Rd_Sector,
  output logic              o_Rd_Last,
  output logic              o_Full,
  output logic [DROP_W-1:0] o_Dropped
);

  localparam int unsigned IDX_W  = $clog2(SECTOR_BYTES);
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned CNT_W  = $clog2(SLOTS + 1);
  localparam logic [IDX_W:0]   WR_FULL = (IDX_W + 1)'(SECTOR_BYTES);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(SECTOR_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOTS);

  // Write side
  logic [IDX_W:0]      wr_idx_q;
  logic [SLOT_W-1:0]   wr_slot_q;
  logic                bad_q;
  logic [CNT_W-1:0]    count_q;
  logic [DROP_W-1:0]   drop_q;
  logic [7:0]          tag_q [SLOTS];

  logic                full;
  logic                wr_room;
  logic                wr_en;
  logic                wr_overrun;
  logic [IDX_W:0]      wr_len;
  logic                commit;
  logic                drop;

  // Read side
  rd_state_e           state_q, state_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
  logic                rd_en;
  logic                rd_valid;
  logic                rd_release;
  logic [7:0]          ram_rd_data;

  assign full       = (count_q == CNT_MAX);
  assign wr_room    = (wr_idx_q != WR_FULL) && !full;
  assign wr_en      = i_Valid && wr_room;
  assign wr_overrun = i_Valid && !wr_room;
  // A byte arriving alongside i_Done still counts toward the ending sector.
  assign wr_len     = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
  assign commit     = i_Done && !i_CRCError && !bad_q && !wr_overrun && (wr_len == WR_FULL);
  assign drop       = i_Done && !commit;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_idx_q  <= '0;
      wr_slot_q <= '0;
      bad_q     <= 1'b0;
      count_q   <= '0;
      drop_q    <= '0;
      tag_q     <= '{default: '0};
    end else begin
      if (i_Done) begin
        wr_idx_q <= '0;
        bad_q    <= 1'b0;
      end else begin
        if (wr_en)      wr_idx_q <= wr_idx_q + 1'b1;
        if (wr_overrun) bad_q    <= 1'b1;
      end
      if (commit) begin
        tag_q[wr_slot_q] <= i_Sector;
        wr_slot_q        <= wr_slot_q + 1'b1;
      end
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      case ({commit, rd_release})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  sector_ram #(
    .SLOTS        (SLOTS),
    .SECTOR_BYTES (SECTOR_BYTES)
  ) u_ram (
    .clk     (i_Clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_slot_q, wr_idx_q[IDX_W-1:0]}),
    .wr_data (i_Data),
    .rd_en   (rd_en),
    .rd_addr ({rd_slot_q, rd_idx_q}),
    .rd_data (ram_rd_data)
  );

`ifdef SECTOR_BUFFER_PACE_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    rd_slot_d  = rd_slot_q;
    rd_en      = 1'b0;
    rd_valid   = 1'b0;
    rd_release = 1'b0;
`ifdef SECTOR_BUFFER_PACE_EN
    hold_d     = hold_q;
`endif
    unique case (state_q)
      R_IDLE: begin
        if (count_q != '0) state_d = R_FETCH;
      end
      R_FETCH: begin
        rd_en   = 1'b1;
        state_d = R_VALID;
      end
      R_VALID: begin
        rd_valid = 1'b1;
        if (i_Rd_Ready) begin
          if (rd_idx_q == RD_LAST) begin
            rd_release = 1'b1;
            rd_slot_d  = rd_slot_q + 1'b1;
            rd_idx_d   = '0;
            state_d    = R_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
`ifdef SECTOR_BUFFER_PACE_EN
            state_d  = R_HOLD;
            hold_d   = HOLD_W'(HOLD_CYCLES - 1);
`else
            state_d  = R_FETCH;
`endif
          end
        end
      end
`ifdef SECTOR_BUFFER_PACE_EN
      R_HOLD: begin
        if (hold_q == '0) state_d = R_FETCH;
        else              hold_d  = hold_q - 1'b1;
      end
`endif
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= R_IDLE;
      rd_idx_q  <= '0;
      rd_slot_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      rd_slot_q <= rd_slot_d;
    end
  end

  // Gate with valid: the RAM read register is unreset and tags are stale between sectors.
  assign o_Rd_Valid  = rd_valid;
  assign o_Rd_Data   = rd_valid ? ram_rd_data : 8'h00;
  assign o_Rd_Sector = rd_valid ? tag_q[rd_slot_q] : 8'h00;
  assign o_Rd_Last   = rd_valid && (rd_idx_q == RD_LAST);
  assign o_Full      = full;
  assign o_Dropped   = drop_q;

endmodule

// File: tb/tb_sector_buffer.sv
// Self-checking bench for sector_buffer: directed scenarios plus randomized sectors against a queue model.
module tb_sector_buffer;

  localparam int unsigned SB   = 4;
  localparam int unsigned NS   = 2;
  localparam int unsigned HOLD = 10;
`ifdef SECTOR_BUFFER_PACE_EN
  localparam int GAP = HOLD + 2;
`else
  localparam int GAP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_Data = '0;
  logic       i_Valid = 1'b0;
  logic       i_Done = 1'b0;
  logic       i_CRCError = 1'b0;
  logic [7:0] i_Sector = '0;
  logic       i_Rd_Ready = 1'b0;
  logic [7:0] o_Rd_Data;
  logic       o_Rd_Valid;
  logic [7:0] o_Rd_Sector;
  logic       o_Rd_Last;
  logic       o_Full;
  logic [7:0] o_Dropped;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sector_buffer #(
    .SECTOR_BYTES (SB),
    .SLOTS        (NS),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Data      (i_Data),
    .i_Valid     (i_Valid),
    .i_Done      (i_Done),
    .i_CRCError  (i_CRCError),
    .i_Sector    (i_Sector),
    .i_Rd_Ready  (i_Rd_Ready),
    .o_Rd_Data   (o_Rd_Data),
    .o_Rd_Valid  (o_Rd_Valid),
    .o_Rd_Sector (o_Rd_Sector),
    .o_Rd_Last   (o_Rd_Last),
    .o_Full      (o_Full),
    .o_Dropped   (o_Dropped)
  );

  // Reference model: committed sectors in arrival order, plus the expected drop count.
  typedef struct packed {
    logic [7:0]      tag;
    logic [SB*8-1:0] data;
  } sec_t;

  sec_t exp_q[$];
  int   exp_drop = 0;
  int   vectors  = 0;
  int   errors   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_sector(input int len, input logic [7:0] tag, input logic crc,
                             input logic [SB*8-1:0] dw, input bit merge);
    bit   acc;
    sec_t s;
    acc = (len == SB) && !crc && (exp_q.size() < NS);
    for (int i = 0; i < len; i++) begin
      i_Valid = 1'b1;
      i_Data  = (i < SB) ? dw[i*8 +: 8] : 8'($urandom);
      if (merge && i == len - 1) begin
        i_Done = 1'b1; i_Sector = tag; i_CRCError = crc;
      end
      tick();
      i_Valid = 1'b0;
      i_Done  = 1'b0;
      if (!(merge && i == len - 1) && $urandom_range(0, 3) == 0) tick();
    end
    if (!merge) begin
      i_Done = 1'b1; i_Sector = tag; i_CRCError = crc;
      tick();
      i_Done = 1'b0;
    end
    if (acc) begin
      s.tag = tag; s.data = dw;
      exp_q.push_back(s);
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  // Consume every modelled sector; rnd toggles ready to exercise backpressure.
  task automatic drain(input bit rnd);
    int         budget = 4000;
    int         pos = 0;
    int         last_hs = 0;
    bit         stall = 1'b0;
    logic [7:0] pd = '0, ps = '0;
    logic       pl = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      i_Rd_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("full_flag", 32'(o_Full), 32'(exp_q.size() == NS));
      if (stall) begin
        check("hold_valid", 32'(o_Rd_Valid), 32'd1);
        check("hold_data", 32'(o_Rd_Data), 32'(pd));
        check("hold_sector", 32'(o_Rd_Sector), 32'(ps));
        check("hold_last", 32'(o_Rd_Last), 32'(pl));
      end
      if (o_Rd_Valid && i_Rd_Ready) begin
        check("rd_data", 32'(o_Rd_Data), 32'(exp_q[0].data[pos*8 +: 8]));
        check("rd_sector", 32'(o_Rd_Sector), 32'(exp_q[0].tag));
        check("rd_last", 32'(o_Rd_Last), 32'(pos == SB - 1));
        if (!rnd && pos > 0) check("hs_gap", 32'(cyc - last_hs), 32'(GAP));
        last_hs = cyc;
        pos++;
        if (pos == SB) begin
          void'(exp_q.pop_front());
          pos = 0;
        end
        stall = 1'b0;
      end else begin
        stall = o_Rd_Valid;
        pd = o_Rd_Data; ps = o_Rd_Sector; pl = o_Rd_Last;
      end
      tick();
      budget--;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    i_Rd_Ready = 1'b0;
  endtask

  initial begin
    int lat;
    int len;
    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(o_Rd_Valid), 32'd0);
    check("rst_data", 32'(o_Rd_Data), 32'd0);
    check("rst_sector", 32'(o_Rd_Sector), 32'd0);
    check("rst_last", 32'(o_Rd_Last), 32'd0);
    check("rst_full", 32'(o_Full), 32'd0);
    check("rst_dropped", 32'(o_Dropped), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Good sector with ready high, and commit-to-valid latency
    i_Rd_Ready = 1'b1;
    send_sector(SB, 8'h05, 1'b0, 32'h44332211, 1'b0);
    lat = 1;
    while (!o_Rd_Valid && lat < 10) begin
      tick();
      lat++;
    end
    check("commit_latency", 32'(lat), 32'd3);
    drain(1'b0);

    // CRC error: nothing comes out
    send_sector(SB, 8'h06, 1'b1, 32'hA5A5A5A5, 1'b0);
    i_Rd_Ready = 1'b1;
    repeat (6) tick();
    check("crc_no_valid", 32'(o_Rd_Valid), 32'd0);
    check("crc_dropped", 32'(o_Dropped), 32'(exp_drop));
    i_Rd_Ready = 1'b0;

    // Short and long sectors, then an intact good one
    send_sector(SB - 1, 8'h07, 1'b0, 32'h01020304, 1'b0);
    send_sector(SB + 1, 8'h08, 1'b0, 32'h05060708, 1'b1);
    check("shortlong_dropped", 32'(o_Dropped), 32'(exp_drop));
    send_sector(SB, 8'h09, 1'b0, 32'hDEADBEEF, 1'b1);
    drain(1'b0);

    // Overflow: two commits fill the store, a third is dropped
    send_sector(SB, 8'h0A, 1'b0, 32'h10203040, 1'b0);
    send_sector(SB, 8'h0B, 1'b0, 32'h50607080, 1'b0);
    check("ovf_full", 32'(o_Full), 32'd1);
    send_sector(SB, 8'h0C, 1'b0, 32'h90A0B0C0, 1'b0);
    check("ovf_dropped", 32'(o_Dropped), 32'(exp_drop));
    drain(1'b0);

    // Reset mid-readout discards everything
    send_sector(SB, 8'h0D, 1'b0, 32'hCAFEF00D, 1'b0);
    i_Rd_Ready = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_Rd_Valid), 32'd0);
    check("mid_rst_data", 32'(o_Rd_Data), 32'd0);
    check("mid_rst_sector", 32'(o_Rd_Sector), 32'd0);
    check("mid_rst_dropped", 32'(o_Dropped), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    repeat (5) tick();
    check("post_rst_valid", 32'(o_Rd_Valid), 32'd0);
    check("post_rst_full", 32'(o_Full), 32'd0);
    i_Rd_Ready = 1'b0;

    // Randomized sectors against the model
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        case ($urandom_range(0, 4))
          0:       len = SB - 1;
          1:       len = SB + 1;
          default: len = SB;
        endcase
        send_sector(len, 8'($urandom), 1'($urandom_range(0, 3) == 0), 32'($urandom),
                    1'($urandom_range(0, 1)));
        check("rnd_dropped", 32'(o_Dropped), 32'(exp_drop));
        check("rnd_full", 32'(o_Full), 32'(exp_q.size() == NS));
      end
      drain(1'(it % 2));
    end

    // Drop counter saturation
    for (int n = 0; n < 300; n++) send_sector(1, 8'h00, 1'b1, 32'h0, 1'b1);
    check("drop_saturate", 32'(o_Dropped), 32'(exp_drop));
    check("drop_at_max", 32'(o_Dropped), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
